// File: rtl/wb_trace_buffer_if.sv
// Monitored WISHBONE bus bundle: master strobes plus slave terminations.
// Latency: none, wires only.
// Backpressure: none; the trace buffer taps the bus passively through the monitor modport.
//
// Signals: cyc/stb/we/adr/sel/wdat come from the master, rdat/ack/err/rty
// come from the slave. The monitor modport sees everything as an input.
interface wb_trace_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 20,
    parameter int SEL_WIDTH  = 4
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADR_WIDTH-1:0]  adr;
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] wdat;
    logic [DATA_WIDTH-1:0] rdat;
    logic                  ack;
    logic                  err;
    logic                  rty;

    modport master  (output cyc, stb, we, adr, sel, wdat,
                     input  rdat, ack, err, rty);
    modport slave   (input  cyc, stb, we, adr, sel, wdat,
                     output rdat, ack, err, rty);
    modport monitor (input  cyc, stb, we, adr, sel, wdat, rdat, ack, err, rty);
endinterface

// File: rtl/wb_trace_buffer.sv
// Circular WISHBONE transaction trace memory with arm/trigger/post-trigger control.
// Latency: event to RAM 2 edges (stage, then write); read strobe to rd_dat_o 2 edges.
// Backpressure: none; passive tap that keeps up with one event per clock.
//
// Ports: clk_i/rst_neg_i (async active-low); mon = monitored bus (monitor modport);
// arm_i/trig_ext_i/match_* /post_count_i = capture control; state_o, wrapped_o,
// wr_ptr_o, trig_ptr_o = status; rd_en_i/rd_adr_i -> rd_dat_o/rd_valid_o = readback.
// Record layout MSB->LSB: {ts, err, rty, we, sel, adr, dat}.
module wb_trace_buffer #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADR_WIDTH  = 20,
    parameter  int SEL_WIDTH  = 4,
    parameter  int DEPTH_LOG2 = 9,
    parameter  int TS_WIDTH   = 16,
    localparam int REC_WIDTH  = TS_WIDTH + 3 + SEL_WIDTH + ADR_WIDTH + DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_neg_i,
    wb_trace_buffer_if.monitor    mon,
    input  logic                  arm_i,
    input  logic                  trig_ext_i,
    input  logic                  match_en_i,
    input  logic [ADR_WIDTH-1:0]  match_adr_i,
    input  logic [ADR_WIDTH-1:0]  match_mask_i,
    input  logic [DEPTH_LOG2-1:0] post_count_i,
    output logic [1:0]            state_o,
    output logic                  wrapped_o,
    output logic [DEPTH_LOG2-1:0] wr_ptr_o,
    output logic [DEPTH_LOG2-1:0] trig_ptr_o,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2-1:0] rd_adr_i,
    output logic [REC_WIDTH-1:0]  rd_dat_o,
    output logic                  rd_valid_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // st is the decision state and moves at the sampling edge so that an
    // event arriving on the very next clock is judged against the new state.
    // state_o is a one-edge-delayed copy, lining it up with the RAM write.
    state_t                  st;
    logic [DEPTH_LOG2-1:0]   rem;
    logic [TS_WIDTH-1:0]     ts_cnt;

    logic                    stg_vld;
    logic                    stg_trig;
    logic [REC_WIDTH-1:0]    stg_rec;

    logic [REC_WIDTH-1:0]    mem [DEPTH];
    logic [REC_WIDTH-1:0]    rd_raw;
    logic                    rd_pend;

    logic                    bus_evt;
    logic                    match_hit;
    logic                    capturing;
    logic                    capture;
    logic                    trig_fire;
    logic [DATA_WIDTH-1:0]   cap_dat;
    logic [TS_WIDTH-1:0]     ts_rec;

    assign bus_evt   = mon.cyc & mon.stb & (mon.ack | mon.err | mon.rty);
    assign match_hit = match_en_i & bus_evt &
                       (((mon.adr ^ match_adr_i) & match_mask_i) == '0);
    assign capturing = (st == ST_ARMED) || (st == ST_POST);
    // arm_i outranks everything happening in the same cycle.
    assign capture   = bus_evt & ~arm_i & capturing;
    assign trig_fire = ~arm_i & (st == ST_ARMED) & (trig_ext_i | match_hit);
    assign cap_dat   = mon.we ? mon.wdat : mon.rdat;
    // Stored delta counts the edge of the event itself, so the first record
    // after arm reads as the number of cycles since the arm edge.
    assign ts_rec    = (ts_cnt == {TS_WIDTH{1'b1}}) ? ts_cnt : ts_cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rst_neg_i) begin
        if (!rst_neg_i) begin
            st         <= ST_IDLE;
            state_o    <= 2'd0;
            rem        <= '0;
            ts_cnt     <= '0;
            stg_vld    <= 1'b0;
            stg_trig   <= 1'b0;
            stg_rec    <= '0;
            wr_ptr_o   <= '0;
            trig_ptr_o <= '0;
            wrapped_o  <= 1'b0;
            rd_pend    <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_dat_o   <= '0;
        end else begin
            state_o <= st;

            // Readback: second stage of the two-edge read path.
            rd_pend    <= rd_en_i;
            rd_valid_o <= rd_pend;
            if (rd_pend) begin
                rd_dat_o <= rd_raw;
            end

            if (arm_i) begin
                st         <= ST_ARMED;
                rem        <= post_count_i;
                ts_cnt     <= '0;
                stg_vld    <= 1'b0;      // a pending pre-arm record is dropped
                stg_trig   <= 1'b0;
                wr_ptr_o   <= '0;
                trig_ptr_o <= '0;
                wrapped_o  <= 1'b0;
            end else begin
                // Staging register: one record per clock, written next edge.
                stg_vld  <= capture;
                stg_trig <= capture & trig_fire & match_hit;
                if (capture) begin
                    stg_rec <= {ts_rec, mon.err, mon.rty, mon.we, mon.sel,
                                mon.adr, cap_dat};
                end

                if (stg_vld) begin
                    wr_ptr_o <= wr_ptr_o + 1'b1;
                    if (wr_ptr_o == {DEPTH_LOG2{1'b1}}) begin
                        wrapped_o <= 1'b1;
                    end
                    if (stg_trig) begin
                        trig_ptr_o <= wr_ptr_o;
                    end
                end

                // External-only trigger points at the next free slot; a
                // record still in staging owns the current wr_ptr.
                if (trig_fire && !match_hit) begin
                    trig_ptr_o <= wr_ptr_o + DEPTH_LOG2'(stg_vld);
                end

                if (capture) begin
                    ts_cnt <= '0;
                end else if (capturing && ts_cnt != {TS_WIDTH{1'b1}}) begin
                    ts_cnt <= ts_cnt + 1'b1;
                end

                case (st)
                    ST_ARMED: begin
                        if (trig_fire) begin
                            st <= (rem == '0) ? ST_DONE : ST_POST;
                        end
                    end
                    ST_POST: begin
                        if (capture) begin
                            rem <= rem - 1'b1;
                            if (rem == DEPTH_LOG2'(1)) begin
                                st <= ST_DONE;
                            end
                        end
                    end
                    default: begin
                        st <= st;
                    end
                endcase
            end
        end
    end

    // Record RAM: no reset so it maps onto block memory and survives rst_neg_i.
    // Reading in the same block as the write yields the old word on a collision.
    always_ff @(posedge clk_i) begin
        if (stg_vld && !arm_i) begin
            mem[wr_ptr_o] <= stg_rec;
        end
        if (rd_en_i) begin
            rd_raw <= mem[rd_adr_i];
        end
    end
endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;
    localparam int DW = 32;
    localparam int AW = 20;
    localparam int SW = 4;
    localparam int DL = 4;
    localparam int TW = 16;
    localparam int RW = TW + 3 + SW + AW + DW;

    logic          wbc_clk = 1'b0;
    logic          rst_neg = 1'b0;
    logic          arm = 1'b0;
    logic          trig_ext = 1'b0;
    logic          match_en = 1'b0;
    logic [AW-1:0] match_adr = '0;
    logic [AW-1:0] match_mask = '0;
    logic [DL-1:0] post_count = '0;
    logic [1:0]    state;
    logic          wrapped;
    logic [DL-1:0] wr_ptr;
    logic [DL-1:0] trig_ptr;
    logic          rd_en = 1'b0;
    logic [DL-1:0] rd_adr = '0;
    logic [RW-1:0] rd_dat;
    logic          rd_valid;

    int n_checks = 0;
    int n_errors = 0;

    wb_trace_buffer_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .SEL_WIDTH(SW)) bus ();

    wb_trace_buffer #(
        .DATA_WIDTH(DW), .ADR_WIDTH(AW), .SEL_WIDTH(SW), .DEPTH_LOG2(DL), .TS_WIDTH(TW)
    ) dut (
        .clk_i        (wbc_clk),
        .rst_neg_i    (rst_neg),
        .mon          (bus),
        .arm_i        (arm),
        .trig_ext_i   (trig_ext),
        .match_en_i   (match_en),
        .match_adr_i  (match_adr),
        .match_mask_i (match_mask),
        .post_count_i (post_count),
        .state_o      (state),
        .wrapped_o    (wrapped),
        .wr_ptr_o     (wr_ptr),
        .trig_ptr_o   (trig_ptr),
        .rd_en_i      (rd_en),
        .rd_adr_i     (rd_adr),
        .rd_dat_o     (rd_dat),
        .rd_valid_o   (rd_valid)
    );

    always #5 wbc_clk = ~wbc_clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge wbc_clk);
    endtask

    // One-cycle bus termination; term = {err, rty, ack}.
    task automatic evt(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [2:0] term);
        bus.cyc  = 1'b1;
        bus.stb  = 1'b1;
        bus.we   = we;
        bus.adr  = adr;
        bus.sel  = 4'hF;
        bus.wdat = we ? dat : 32'hBAD0_BAD0;
        bus.rdat = we ? 32'h5A5A_5A5A : dat;
        {bus.err, bus.rty, bus.ack} = term;
        @(negedge wbc_clk);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.ack = 1'b0;
        bus.err = 1'b0;
        bus.rty = 1'b0;
    endtask

    task automatic do_arm(input logic [DL-1:0] pc);
        arm        = 1'b1;
        post_count = pc;
        @(negedge wbc_clk);
        arm = 1'b0;
    endtask

    task automatic rd_rec(input logic [DL-1:0] a, output logic [RW-1:0] r);
        rd_en  = 1'b1;
        rd_adr = a;
        @(negedge wbc_clk);
        rd_en = 1'b0;
        @(negedge wbc_clk);
        check("rd_valid", rd_valid, 1);
        r = rd_dat;
    endtask

    // Record field accessors.
    function automatic logic [DW-1:0] f_dat(input logic [RW-1:0] r); return r[31:0];  endfunction
    function automatic logic [AW-1:0] f_adr(input logic [RW-1:0] r); return r[51:32]; endfunction
    function automatic logic          f_we (input logic [RW-1:0] r); return r[56];    endfunction
    function automatic logic          f_rty(input logic [RW-1:0] r); return r[57];    endfunction
    function automatic logic          f_err(input logic [RW-1:0] r); return r[58];    endfunction
    function automatic logic [TW-1:0] f_ts (input logic [RW-1:0] r); return r[74:59]; endfunction

    logic [RW-1:0] rec;
    logic [AW-1:0] t1_adr [4] = '{20'h00100, 20'h00104, 20'h00108, 20'h0010C};
    logic [DW-1:0] t1_dat [4] = '{32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00B3};
    logic          t1_we  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.adr = '0; bus.sel = '0;
        bus.wdat = '0; bus.rdat = '0; bus.ack = 0; bus.err = 0; bus.rty = 0;

        // Reset state
        tick(2);
        check("rst_state", state, 0);
        check("rst_wrapped", wrapped, 0);
        check("rst_wr_ptr", wr_ptr, 0);
        check("rst_trig_ptr", trig_ptr, 0);
        check("rst_rd_dat", rd_dat, 0);
        check("rst_rd_valid", rd_valid, 0);
        rst_neg = 1'b1;
        tick(1);

        // External trigger, post count 4
        do_arm(4'd4);
        for (int i = 0; i < 4; i++) evt(t1_we[i], t1_adr[i], t1_dat[i], 3'b001);
        tick(2);
        check("t1_pre_wr_ptr", wr_ptr, 4);
        check("t1_pre_state", state, 1);
        trig_ext = 1'b1;
        tick(1);
        trig_ext = 1'b0;
        tick(1);
        check("t1_post_state", state, 2);
        check("t1_trig_ptr_early", trig_ptr, 4);
        for (int i = 0; i < 4; i++) evt(1'b1, 20'h00200 + AW'(i), 32'hC0 + DW'(i), 3'b001);
        tick(2);
        check("t1_done_state", state, 3);
        check("t1_wr_ptr", wr_ptr, 8);
        check("t1_trig_ptr", trig_ptr, 4);
        evt(1'b1, 20'h00300, 32'hFFFF, 3'b001);
        tick(2);
        check("t1_done_hold", wr_ptr, 8);
        for (int i = 0; i < 4; i++) begin
            rd_rec(DL'(i), rec);
            check("t1_we", f_we(rec), t1_we[i]);
            check("t1_adr", f_adr(rec), t1_adr[i]);
            check("t1_dat", f_dat(rec), t1_dat[i]);
        end
        rd_rec(4'd0, rec);
        check("t1_ts_first", f_ts(rec), 1);
        rd_rec(4'd1, rec);
        check("t1_ts_b2b", f_ts(rec), 1);

        // Address-match trigger, post count 0
        match_adr  = 20'h10004;
        match_mask = 20'hFFFFC;
        match_en   = 1'b1;
        do_arm(4'd0);
        evt(1'b1, 20'h10000, 32'h1111, 3'b001);
        evt(1'b1, 20'h10007, 32'h2222, 3'b001);
        check("t2_state_not_yet", state, 1);
        tick(1);
        check("t2_state_done", state, 3);
        check("t2_trig_ptr", trig_ptr, 1);
        check("t2_wr_ptr", wr_ptr, 2);
        match_en = 1'b0;

        // Wrap with 16 entries
        do_arm(4'd0);
        for (int i = 0; i < 20; i++) evt(1'b1, AW'(i), 32'h1000 + DW'(i), 3'b001);
        tick(2);
        check("t3_wrapped", wrapped, 1);
        check("t3_wr_ptr", wr_ptr, 4);
        check("t3_state", state, 1);
        rd_rec(4'd0, rec);
        check("t3_addr0", f_dat(rec), 32'h1010);
        rd_rec(4'd4, rec);
        check("t3_addr4", f_dat(rec), 32'h1004);

        // Timestamp deltas and saturation, err termination
        do_arm(4'd0);
        tick(4);
        evt(1'b0, 20'h00050, 32'h7777, 3'b001);
        tick(70000);
        evt(1'b1, 20'h00060, 32'h8888, 3'b100);
        tick(2);
        rd_rec(4'd0, rec);
        check("t4_ts5", f_ts(rec), 5);
        check("t4_err0", f_err(rec), 0);
        rd_rec(4'd1, rec);
        check("t4_ts_sat", f_ts(rec), 16'hFFFF);
        check("t4_err1", f_err(rec), 1);
        check("t4_rty", f_rty(rec), 0);
        check("t4_we", f_we(rec), 1);
        check("t4_dat", f_dat(rec), 32'h8888);

        // arm beats a coincident trigger; async reset in POST
        arm        = 1'b1;
        trig_ext   = 1'b1;
        post_count = 4'd2;
        tick(1);
        arm      = 1'b0;
        trig_ext = 1'b0;
        tick(1);
        check("t5_arm_wins", state, 1);
        trig_ext = 1'b1;
        tick(1);
        trig_ext = 1'b0;
        tick(1);
        check("t5_post", state, 2);
        evt(1'b1, 20'h00033, 32'h5555, 3'b001);
        tick(2);
        check("t5_still_post", state, 2);
        rd_rec(4'd0, rec);
        check("t5_pre_dat", f_dat(rec), 32'h5555);
        #2;
        rst_neg = 1'b0;
        #1;
        check("t5_rst_state", state, 0);
        check("t5_rst_wr_ptr", wr_ptr, 0);
        check("t5_rst_rd_dat", rd_dat, 0);
        check("t5_rst_rd_valid", rd_valid, 0);
        tick(2);
        rst_neg = 1'b1;
        tick(1);
        rd_rec(4'd0, rec);
        check("t5_kept_dat", f_dat(rec), 32'h5555);
        check("t5_kept_adr", f_adr(rec), 20'h00033);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Parametrised WISHBONE transaction trace buffer for the control bus. It replaces the fixed single-cycle debug registers on the PCI control master with a circular record memory that has an arm/trigger/post-trigger sequence, address-match triggering and per-record timestamp deltas. It sits passively on any master/slave pair in the wbc_clk domain. Its read port feeds the debug bus mux or a WISHBONE slave wrapper.

## Interface
- DATA_WIDTH, 32: bus data width.
- ADR_WIDTH, 20: bus address width.
- SEL_WIDTH, 4: byte-select width.
- DEPTH_LOG2, 9: log2 of record count (512 records).
- TS_WIDTH, 16: timestamp-delta width.
- REC_WIDTH, derived: TS_WIDTH+3+SEL_WIDTH+ADR_WIDTH+DATA_WIDTH. Record layout MSB→LSB: {ts, err, rty, we, sel, adr, dat}.

Ports:
- clk_i in 1: WISHBONE clock. Single clock; the whole block is synchronous to it.
- rst_neg_i in 1: reset, asynchronous, active-low.
- mon_cyc_i, mon_stb_i, mon_we_i in 1 each: monitored master strobes.
- mon_adr_i in ADR_WIDTH: monitored address.
- mon_sel_i in SEL_WIDTH: monitored byte select.
- mon_wdat_i in DATA_WIDTH: master write data.
- mon_rdat_i in DATA_WIDTH: slave read data.
- mon_ack_i, mon_err_i, mon_rty_i in 1 each: slave terminations.
- arm_i in 1: single-cycle pulse; arms capture.
- trig_ext_i in 1: external trigger, level-sampled.
- match_en_i in 1: enables the address-match trigger.
- match_adr_i in ADR_WIDTH: match address.
- match_mask_i in ADR_WIDTH: bits set to 1 take part in the compare.
- post_count_i in DEPTH_LOG2: records captured after the trigger; latched at arm.
- state_o out 2: 0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- wrapped_o out 1: sticky; set when the write pointer wraps.
- wr_ptr_o out DEPTH_LOG2: next write address.
- trig_ptr_o out DEPTH_LOG2: address of the trigger record.
- rd_en_i in 1: read strobe.
- rd_adr_i in DEPTH_LOG2: read address.
- rd_dat_o out REC_WIDTH: record data.
- rd_valid_o out 1: rd_dat_o valid.

## Operation
- Event: mon_cyc_i & mon_stb_i & (mon_ack_i | mon_err_i | mon_rty_i) at a clock edge.
- Captured data is mon_wdat_i if mon_we_i, else mon_rdat_i.
- State machine:
  - IDLE to ARMED on arm_i.
  - ARMED captures events. A trigger moves it to POST, or to DONE if the latched post count is 0.
  - POST captures events and decrements the remaining count per capture. The capture that brings the count to 0 moves it to DONE.
  - DONE captures nothing and holds all pointers.
- arm_i from any state: enters ARMED, wr_ptr=0, wrapped=0, ts counter=0, trig_ptr=0, latches post_count_i.
- Trigger is valid in ARMED only. Either source fires it:
  - trig_ext_i high. trig_ptr = wr_ptr at that edge.
  - match_en_i and an event with ((mon_adr_i ^ match_adr_i) & match_mask_i)==0. That event is captured and trig_ptr = its write address.
- Both trigger sources in the same cycle: treated as a single trigger, using the match rule for trig_ptr.
- arm_i together with a trigger: arm wins and the trigger is ignored.
- Timestamp: counter increments every clock in ARMED/POST and saturates at all-ones. Each record stores the counter value at its event. The counter clears to 0 on capture, so the next count is relative to that record. The first record's ts is cycles since arm.
- Wrap: wr_ptr increments modulo 2^DEPTH_LOG2. Going from max to 0 sets wrapped_o. Old records are overwritten.
- Reset: asynchronous to IDLE. All outputs and pointers go to 0. RAM contents are not cleared.

## Timing
- Event at edge N: registered into a staging stage at N, written to RAM at N+1. wr_ptr_o updates at N+1.
- state_o updates at edge N+1 for a match trigger and for the transition into DONE. For an external trigger sampled at N, state_o also updates at N+1.
- Back-to-back events (one per clock) are captured with no loss.
- Read: rd_en_i at edge N gives rd_dat_o and rd_valid_o=1 after edge N+1, held for one cycle. Reads are allowed in every state.
- Read and write to the same address in the same cycle returns the old data (read-first).
- Reset values: state_o=0, wrapped_o=0, wr_ptr_o=0, trig_ptr_o=0, rd_dat_o=0, rd_valid_o=0.

## Test plan
- Arm with post_count=4, then 3 writes and 1 read with ack. Pulse trig_ext. Then 4 more acked cycles → state DONE, wr_ptr=8, trig_ptr=4. Records 0-3 carry the correct we/adr/dat, and the read record holds mon_rdat_i.
- match_adr=0x10004, mask=0xFFFFC, post_count=0. Access 0x10000 then 0x10007 → trigger on the second, trig_ptr=1, DONE at the next edge, wr_ptr=2.
- DEPTH_LOG2=4, no trigger, 20 events → wrapped_o=1, wr_ptr=4, and address 0 holds event 16.
- Events 5 and 70000 cycles after arm → ts=5, then ts=0xFFFF (saturated). An err-terminated cycle sets err=1 and we reflects the cycle.
- arm_i and trig_ext_i together → state ARMED, not POST. Assert rst_neg_i low while in POST → outputs are 0 immediately, then a read of an earlier address returns the pre-reset record.
